// File: rtl/lvds_frame_pkg.sv
// Shared word tags, framer state encoding and sizing helper for the LVDS frame transmitter.
package lvds_frame_pkg;

    localparam logic [1:0] TAG_IDLE = 2'b00;
    localparam logic [1:0] TAG_HDR  = 2'b01;
    localparam logic [1:0] TAG_DATA = 2'b10;
    localparam logic [1:0] TAG_CSUM = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_CSUM
    } frame_state_e;

    // Serializer words needed to carry one sample of sample_w bits in pw-bit payloads.
    function automatic int unsigned wps(input int unsigned sample_w, input int unsigned pw);
        return (sample_w + pw - 1) / pw;
    endfunction

endpackage

// File: rtl/lvds_chan_hold.sv
// Per-channel sample holding register with freshness flag and overwrite (overrun) detection.
module lvds_chan_hold
    import lvds_frame_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [SAMPLE_W-1:0] sample_i,
    input  logic                valid_i,
    input  logic                snap_i,
    output logic [SAMPLE_W-1:0] hold_o,
    output logic                fresh_o,
    output logic                overrun_o
);

    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic                fresh_q, fresh_d;

    // A new sample wins over the snapshot clear; the snapshot sees the old hold value.
    always_comb begin
        hold_d  = hold_q;
        fresh_d = fresh_q;
        if (valid_i) begin
            hold_d  = sample_i;
            fresh_d = 1'b1;
        end else if (snap_i) begin
            fresh_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q  <= '0;
            fresh_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fresh_q <= fresh_d;
        end
    end

    assign hold_o    = hold_q;
    assign fresh_o   = fresh_q;
    assign overrun_o = valid_i & fresh_q & ~snap_i;

endmodule

// File: rtl/lvds_frame_tx.sv
// Multi-channel framer for the 10-bit LVDS serializer: header/seq, tagged sample words, checksum,
// with idle words between frames and whenever the PLL is unlocked.
module lvds_frame_tx
    import lvds_frame_pkg::*;
#(
    parameter int unsigned       DATA_W   = 10,
    parameter int unsigned       SAMPLE_W = 16,
    parameter int unsigned       NUM_CH   = 4,
    parameter logic [DATA_W-3:0] IDLE_PAT = 8'hA5,
    parameter int unsigned       GAP_W    = 16
) (
    input  logic                       sysclk,
    input  logic                       rst,
    input  logic                       lock_n,
    input  logic                       enable,
    input  logic                       mode,
    input  logic [GAP_W-1:0]           frame_gap,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
    input  logic [NUM_CH-1:0]          sample_valid,
    output logic [DATA_W-1:0]          datatx,
    output logic                       frame_active,
    output logic [DATA_W-3:0]          seq,
    output logic [7:0]                 overrun_cnt
);

    localparam int unsigned PW   = DATA_W - 2;
    localparam int unsigned WPS  = wps(SAMPLE_W, PW);
    localparam int unsigned PADW = WPS * PW;
    localparam int unsigned CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned SUBW = (WPS > 1) ? $clog2(WPS) : 1;

    localparam logic [CHW-1:0]   LAST_CH  = CHW'(NUM_CH - 1);
    localparam logic [SUBW-1:0]  LAST_SUB = SUBW'(WPS - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = '1;

    frame_state_e state_q, state_d;

    logic [CHW-1:0]    ch_q, ch_d;
    logic [SUBW-1:0]   sub_q, sub_d;
    logic [PW-1:0]     seq_q, seq_d;
    logic [PW-1:0]     csum_q, csum_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [7:0]        ovr_q, ovr_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              act_q, act_d;

    logic [NUM_CH-1:0][SAMPLE_W-1:0] hold;
    logic [NUM_CH-1:0][SAMPLE_W-1:0] fb_q;
    logic [NUM_CH-1:0]               fresh;
    logic [NUM_CH-1:0]               ovr_pulse;

    logic          launch;
    logic          last_word;
    logic          snap;
    logic [PADW-1:0] padded;
    logic [PADW-1:0] shifted;
    int unsigned   shamt;
    logic [PW-1:0] payload;
    int unsigned   ovr_sum;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        lvds_chan_hold #(
            .SAMPLE_W (SAMPLE_W)
        ) u_hold (
            .clk_i     (sysclk),
            .rst_i     (rst),
            .sample_i  (sample_in[c*SAMPLE_W +: SAMPLE_W]),
            .valid_i   (sample_valid[c]),
            .snap_i    (snap),
            .hold_o    (hold[c]),
            .fresh_o   (fresh[c]),
            .overrun_o (ovr_pulse[c])
        );
    end

    assign launch    = enable & ~lock_n & (mode ? (gap_q >= frame_gap) : (&fresh));
    assign last_word = (ch_q == LAST_CH) && (sub_q == LAST_SUB);

    // Data payload: sample zero-padded at the top, most significant word first.
    always_comb begin
        padded                 = '0;
        padded[SAMPLE_W-1:0]   = fb_q[ch_q];
        shamt                  = PW * (WPS - 1 - 32'(sub_q));
        shifted                = padded >> shamt;
        payload                = shifted[PW-1:0];
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        sub_d   = sub_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) state_d = ST_HDR;
            end
            ST_HDR: begin
                state_d = ST_DATA;
                ch_d    = '0;
                sub_d   = '0;
            end
            ST_DATA: begin
                if (last_word) begin
                    state_d = ST_CSUM;
                end else if (sub_q == LAST_SUB) begin
                    sub_d = '0;
                    ch_d  = ch_q + CHW'(1);
                end else begin
                    sub_d = sub_q + SUBW'(1);
                end
            end
            ST_CSUM: begin
                state_d = launch ? ST_HDR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (lock_n) state_d = ST_IDLE;
    end

    // HDR is only ever entered from IDLE or CSUM on a launch, so this marks the snapshot cycle.
    assign snap = (state_d == ST_HDR);

    always_comb begin
        seq_d  = seq_q;
        csum_d = csum_q;
        tx_d   = {TAG_IDLE, IDLE_PAT};
        act_d  = 1'b0;
        if (!lock_n) begin
            case (state_q)
                ST_HDR: begin
                    tx_d   = {TAG_HDR, seq_q};
                    act_d  = 1'b1;
                    csum_d = seq_q;
                end
                ST_DATA: begin
                    tx_d   = {TAG_DATA, payload};
                    act_d  = 1'b1;
                    csum_d = csum_q + payload;
                end
                ST_CSUM: begin
                    tx_d   = {TAG_CSUM, csum_q};
                    act_d  = 1'b1;
                    seq_d  = seq_q + PW'(1);
                end
                default: ;
            endcase
        end
    end

    // The gap timer holds during HDR/DATA so that frame_gap counts idle words between frames.
    always_comb begin
        gap_d = gap_q;
        if (snap) begin
            gap_d = '0;
        end else if ((state_q == ST_IDLE) || (state_q == ST_CSUM)) begin
            gap_d = (gap_q == GAP_MAX) ? gap_q : gap_q + GAP_W'(1);
        end
    end

    always_comb begin
        ovr_sum = 32'(ovr_q);
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ovr_sum = ovr_sum + 32'(ovr_pulse[c]);
        end
        ovr_d = (ovr_sum > 32'd255) ? 8'hFF : 8'(ovr_sum);
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            sub_q   <= '0;
            seq_q   <= '0;
            csum_q  <= '0;
            gap_q   <= '0;
            ovr_q   <= '0;
            tx_q    <= {TAG_IDLE, IDLE_PAT};
            act_q   <= 1'b0;
            fb_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            sub_q   <= sub_d;
            seq_q   <= seq_d;
            csum_q  <= csum_d;
            gap_q   <= gap_d;
            ovr_q   <= ovr_d;
            tx_q    <= tx_d;
            act_q   <= act_d;
            if (snap) fb_q <= hold;
        end
    end

    assign datatx       = tx_q;
    assign frame_active = act_q;
    assign seq          = seq_q;
    assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_lvds_frame_tx.sv
// Randomised bench for lvds_frame_tx: a queue-of-words frame model predicts every output each cycle,
// and a few directed scenarios pin the model with hand-computed words.
module tb_lvds_frame_tx;

    localparam int DATA_W   = 10;
    localparam int SAMPLE_W = 16;
    localparam int NUM_CH   = 4;
    localparam int GAP_W    = 16;
    localparam int PW       = 8;
    localparam int WPS      = 2;
    localparam logic [9:0] IDLE_WORD = 10'h0A5;

    logic                       sysclk = 1'b0;
    logic                       rst = 1'b0;
    logic                       lock_n = 1'b1;
    logic                       enable = 1'b0;
    logic                       mode = 1'b0;
    logic [GAP_W-1:0]           frame_gap = '0;
    logic [NUM_CH*SAMPLE_W-1:0] sample_in = '0;
    logic [NUM_CH-1:0]          sample_valid = '0;
    logic [DATA_W-1:0]          datatx;
    logic                       frame_active;
    logic [PW-1:0]              seq;
    logic [7:0]                 overrun_cnt;

    always #5 sysclk = ~sysclk;

    lvds_frame_tx #(
        .DATA_W   (DATA_W),
        .SAMPLE_W (SAMPLE_W),
        .NUM_CH   (NUM_CH),
        .IDLE_PAT (8'hA5),
        .GAP_W    (GAP_W)
    ) dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .lock_n       (lock_n),
        .enable       (enable),
        .mode         (mode),
        .frame_gap    (frame_gap),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .datatx       (datatx),
        .frame_active (frame_active),
        .seq          (seq),
        .overrun_cnt  (overrun_cnt)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    bit          cmp_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [SAMPLE_W-1:0] m_hold [NUM_CH];
    bit                  m_fresh [NUM_CH];
    logic [9:0]          m_q [$];
    int                  m_seq, m_ovr, m_gap;
    logic [9:0]          e_datatx;
    logic                e_active;
    logic [7:0]          e_seq, e_ovr;

    task automatic m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_hold[c]  = '0;
            m_fresh[c] = 0;
        end
        m_q.delete();
        m_seq = 0; m_ovr = 0; m_gap = 0;
        e_datatx = IDLE_WORD; e_active = 0; e_seq = 0; e_ovr = 0;
    endtask

    task automatic m_build_frame();
        int sum;
        int p;
        sum = m_seq;
        m_q.push_back({2'b01, 8'(m_seq)});
        for (int c = 0; c < NUM_CH; c++) begin
            for (int w = 0; w < WPS; w++) begin
                p = (int'(m_hold[c]) >> (PW * (WPS - 1 - w))) & 8'hFF;
                sum += p;
                m_q.push_back({2'b10, 8'(p)});
            end
            m_fresh[c] = 0;
        end
        m_q.push_back({2'b11, 8'(sum % 256)});
    endtask

    task automatic m_step();
        int qs;
        bit launch;
        bit allf;
        qs = m_q.size();
        launch = 0;
        if (lock_n) begin
            e_datatx = IDLE_WORD;
            e_active = 0;
            m_q.delete();
        end else begin
            if (qs == 0) begin
                e_datatx = IDLE_WORD;
                e_active = 0;
            end else begin
                e_datatx = m_q.pop_front();
                e_active = 1;
                if (qs == 1) m_seq = (m_seq + 1) % 256;
            end
            if (qs <= 1 && enable) begin
                allf = 1;
                for (int c = 0; c < NUM_CH; c++) allf &= m_fresh[c];
                launch = mode ? (m_gap >= int'(frame_gap)) : allf;
            end
            if (launch) m_build_frame();
        end
        if (launch) m_gap = 0;
        else if (qs <= 1 && m_gap < 65535) m_gap++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sample_valid[c]) begin
                if (m_fresh[c] && !launch && m_ovr < 255) m_ovr++;
                m_hold[c]  = sample_in[c*SAMPLE_W +: SAMPLE_W];
                m_fresh[c] = 1;
            end
        end
        e_seq = 8'(m_seq);
        e_ovr = 8'(m_ovr);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge sysclk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    initial begin
        forever begin
            @(negedge sysclk);
            if (cmp_en) begin
                chk("datatx", 32'(datatx), 32'(e_datatx));
                chk("frame_active", 32'(frame_active), 32'(e_active));
                chk("seq", 32'(seq), 32'(e_seq));
                chk("overrun_cnt", 32'(overrun_cnt), 32'(e_ovr));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] s0, input logic [15:0] s1,
                            input logic [15:0] s2, input logic [15:0] s3);
        sample_in    = {s3, s2, s1, s0};
        sample_valid = '1;
        step(1);
        sample_valid = '0;
    endtask

    // Waits (at negedges) for a word carrying the given tag; an expired budget counts as a failure.
    task automatic wait_tag(input logic [1:0] tag, input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sysclk);
            if (datatx[9:8] == tag) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no tag %0d word within 40 cycles, expected one", name, tag);
        end
    endtask

    logic [9:0] got [10];
    logic [9:0] exp_frame [10] = '{10'h100, 10'h212, 10'h234, 10'h2AB, 10'h2CD,
                                   10'h200, 10'h201, 10'h2FF, 10'h2FF, 10'h3BD};

    initial begin
        bit ok;
        bit seen_csum;
        bit wrapped;
        bit after_csum;
        int run;
        int gap_meas;
        logic [7:0] seq_prev;

        #1;
        // Reset values and unlocked behaviour
        rst = 1'b1;
        #1;
        chk("rst_datatx", 32'(datatx), 32'h0A5);
        chk("rst_active", 32'(frame_active), 32'h0);
        chk("rst_seq", 32'(seq), 32'h0);
        chk("rst_ovr", 32'(overrun_cnt), 32'h0);
        step(2);
        rst = 1'b0;
        cmp_en = 1;
        enable = 1'b1;
        lock_n = 1'b1;
        load_all(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        step(6);
        chk("unlocked_datatx", 32'(datatx), 32'h0A5);
        chk("unlocked_active", 32'(frame_active), 32'h0);

        // Mode 0 reference frame
        do_reset();
        lock_n = 1'b0;
        enable = 1'b1;
        mode   = 1'b0;
        step(2);
        load_all(16'h1234, 16'hABCD, 16'h0001, 16'hFFFF);
        wait_tag(2'b01, "ref_hdr", ok);
        if (ok) begin
            got[0] = datatx;
            for (int i = 1; i < 10; i++) begin
                @(negedge sysclk);
                got[i] = datatx;
            end
            for (int i = 0; i < 10; i++) chk($sformatf("ref_word%0d", i), 32'(got[i]), 32'(exp_frame[i]));
            chk("ref_seq", 32'(seq), 32'h1);
        end
        step(3);

        // Overrun on channel 2, newer sample carried
        do_reset();
        lock_n = 1'b0;
        enable = 1'b0;
        sample_in[2*SAMPLE_W +: SAMPLE_W] = 16'h5A5A;
        sample_valid = 4'b0100;
        step(1);
        sample_in[2*SAMPLE_W +: SAMPLE_W] = 16'hBEEF;
        step(1);
        sample_valid = '0;
        chk("ovr_one", 32'(overrun_cnt), 32'h1);
        enable = 1'b1;
        sample_valid = 4'b1011;
        step(1);
        sample_valid = '0;
        wait_tag(2'b01, "ovr_hdr", ok);
        if (ok) begin
            for (int i = 1; i < 7; i++) begin
                @(negedge sysclk);
                got[i] = datatx;
            end
            chk("ovr_ch2_hi", 32'(got[5]), 32'h2BE);
            chk("ovr_ch2_lo", 32'(got[6]), 32'h2EF);
        end
        step(12);

        // Lock loss on the third data word, relock, then back-to-back frames
        do_reset();
        lock_n = 1'b0;
        enable = 1'b1;
        mode   = 1'b0;
        load_all(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        wait_tag(2'b01, "abort_hdr", ok);
        if (ok) begin
            repeat (3) @(negedge sysclk);
            lock_n = 1'b1;
            @(negedge sysclk);
            chk("abort_idle", 32'(datatx), 32'h0A5);
            seen_csum = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge sysclk);
                if (datatx[9:8] == 2'b11) seen_csum = 1;
            end
            chk("abort_no_csum", 32'(seen_csum), 32'h0);
            chk("abort_seq", 32'(seq), 32'h0);
        end
        step(1);
        lock_n = 1'b0;
        load_all(16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0);
        wait_tag(2'b01, "relock_hdr", ok);
        if (ok) begin
            chk("relock_hdr_word", 32'(datatx), 32'h100);
            step(2);
            load_all(16'hCAFE, 16'hF00D, 16'h0BAD, 16'hD00D);
            wait_tag(2'b11, "b2b_csum", ok);
            if (ok) begin
                @(negedge sysclk);
                chk("b2b_hdr_word", 32'(datatx), 32'h101);
            end
        end
        step(14);

        // Mode 1: gap-timed stale frames, seq wrap
        do_reset();
        lock_n    = 1'b0;
        enable    = 1'b1;
        mode      = 1'b1;
        frame_gap = 16'd5;
        wrapped = 0; after_csum = 0; run = 0; gap_meas = -1; seq_prev = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            @(negedge sysclk);
            if (seq_prev == 8'hFF && seq == 8'h00) wrapped = 1;
            seq_prev = seq;
            if (datatx == IDLE_WORD) begin
                run++;
            end else begin
                if (datatx[9:8] == 2'b01 && after_csum && gap_meas < 0) gap_meas = run;
                if (datatx[9:8] == 2'b11) after_csum = 1;
                run = 0;
            end
        end
        chk("gap_idle_words", 32'(gap_meas), 32'd5);
        chk("seq_wrapped", 32'(wrapped), 32'h1);
        step(1);

        // Randomised traffic
        do_reset();
        mode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            sample_valid = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    sample_valid[c] = 1'b1;
                    sample_in[c*SAMPLE_W +: SAMPLE_W] = 16'($urandom);
                end
            end
            if (lock_n) lock_n = ($urandom_range(0, 3) != 0);
            else lock_n = ($urandom_range(0, 79) == 0);
            enable = ($urandom_range(0, 19) != 0);
            if (i % 600 == 0) begin
                mode      = ~mode;
                frame_gap = 16'($urandom_range(0, 6));
            end
            rst = (i % 1100 == 1099);
            step(1);
        end
        rst = 1'b0;
        sample_valid = '0;
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
